// File: rtl/serial_to_nibble.sv
// Serial-to-parallel front end: gathers WIDTH qualified serial bits per start-framed
// word and presents the completed word with a one-cycle ce_out strobe.
module serial_to_nibble #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] d_out,
  output logic             ce_out,
  output logic             busy,
  output logic             abort
);

  // state | meaning
  // IDLE  | waiting for start, serial input ignored
  // SHIFT | collecting bits, busy asserted
  // DONE  | word just completed, ce_out asserted for this cycle only
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             abort_q, abort_d;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (MSB_FIRST) shifted = {sreg_q[WIDTH-2:0], sin};
    else           shifted = {sin, sreg_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // start wins over a coincident valid bit: the bit belongs to the dead frame
        if (start) begin
          sreg_d  = '0;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (sin_valid) begin
          sreg_d = shifted;
          if (cnt_q == LAST_BIT) begin
            state_d = DONE;
            dout_d  = shifted;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      abort_q <= abort_d;
    end
  end

  assign d_out  = dout_q;
  assign ce_out = (state_q == DONE);
  assign busy   = (state_q == SHIFT);
  assign abort  = abort_q;

endmodule

// File: tb/tb_serial_to_nibble.sv
// Directed bench for serial_to_nibble: an MSB-first and an LSB-first instance share
// the same stimulus; each step advances one edge and checks outputs 1ns later.
module tb_serial_to_nibble;

  logic       clk = 1'b0;
  logic       clr, start, sin, sin_valid;
  logic [3:0] d_out_m, d_out_l;
  logic       ce_m, busy_m, abort_m;
  logic       ce_l, busy_l, abort_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_to_nibble #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clr(clr), .start(start), .sin(sin), .sin_valid(sin_valid),
    .d_out(d_out_m), .ce_out(ce_m), .busy(busy_m), .abort(abort_m));

  serial_to_nibble #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clr(clr), .start(start), .sin(sin), .sin_valid(sin_valid),
    .d_out(d_out_l), .ce_out(ce_l), .busy(busy_l), .abort(abort_l));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the MSB-first instance's four outputs in one call.
  task automatic chk_m(input string tag, input logic [3:0] d, input logic ce,
                       input logic bz, input logic ab);
    chk({tag, ".d_out"}, {4'h0, d_out_m}, {4'h0, d});
    chk({tag, ".ce_out"}, {7'h0, ce_m}, {7'h0, ce});
    chk({tag, ".busy"}, {7'h0, busy_m}, {7'h0, bz});
    chk({tag, ".abort"}, {7'h0, abort_m}, {7'h0, ab});
  endtask

  task automatic bit_in(input logic b);
    sin_valid = 1'b1;
    sin       = b;
    tick();
    sin_valid = 1'b0;
    sin       = 1'b0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;

    // 1: reset then idle
    tick(); tick();
    clr = 1'b0;
    tick(); tick(); tick();
    chk_m("t1_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t1_lsb_d_out", {4'h0, d_out_l}, 8'h00);

    // 2: minimum frame 1,0,1,1
    start = 1'b1; tick(); start = 1'b0;
    chk_m("t2_after_start", 4'b0000, 1'b0, 1'b1, 1'b0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    chk_m("t2_bit3", 4'b0000, 1'b0, 1'b1, 1'b0);
    bit_in(1'b1);
    chk_m("t2_done", 4'b1011, 1'b1, 1'b0, 1'b0);
    chk("t2_lsb_d_out", {4'h0, d_out_l}, 8'h0D);
    tick();
    chk_m("t2_after", 4'b1011, 1'b0, 1'b0, 1'b0);

    // 3: gap of three cycles mid-frame
    start = 1'b1; tick(); start = 1'b0;
    bit_in(1'b1); bit_in(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_m("t3_gap", 4'b1011, 1'b0, 1'b1, 1'b0);
    end
    bit_in(1'b0);
    chk_m("t3_bit3", 4'b1011, 1'b0, 1'b1, 1'b0);
    bit_in(1'b1);
    chk_m("t3_done", 4'b1001, 1'b1, 1'b0, 1'b0);
    tick();
    chk_m("t3_after", 4'b1001, 1'b0, 1'b0, 1'b0);

    // 4: restart after two bits, then start held with valid bits (discarded)
    start = 1'b1; tick(); start = 1'b0;
    bit_in(1'b1); bit_in(1'b1);
    start = 1'b1; tick();
    chk_m("t4_abort1", 4'b1001, 1'b0, 1'b1, 1'b1);
    sin_valid = 1'b1; sin = 1'b1;
    tick();
    chk_m("t4_abort_held", 4'b1001, 1'b0, 1'b1, 1'b1);
    start = 1'b0; sin_valid = 1'b0; sin = 1'b0;
    bit_in(1'b1);
    chk_m("t4_bit0", 4'b1001, 1'b0, 1'b1, 1'b0);
    bit_in(1'b0); bit_in(1'b0);
    chk_m("t4_bit2", 4'b1001, 1'b0, 1'b1, 1'b0);
    bit_in(1'b0);
    chk_m("t4_done", 4'b1000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_m("t4_after", 4'b1000, 1'b0, 1'b0, 1'b0);

    // 5: clr mid-frame, then bits without start are ignored
    start = 1'b1; tick(); start = 1'b0;
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk_m("t5_clr", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t5_lsb_d_out", {4'h0, d_out_l}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      bit_in(1'b1);
      chk_m("t5_nostart", 4'b0000, 1'b0, 1'b0, 1'b0);
    end

    // 6: back-to-back frames, start in the DONE cycle
    start = 1'b1; tick(); start = 1'b0;
    bit_in(1'b0); bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
    chk_m("t6_first", 4'b0001, 1'b1, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk_m("t6_b2b", 4'b0001, 1'b0, 1'b1, 1'b0);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    chk_m("t6_bit2", 4'b0001, 1'b0, 1'b1, 1'b0);
    bit_in(1'b1);
    chk_m("t6_second", 4'b1111, 1'b1, 1'b0, 1'b0);
    tick();
    chk_m("t6_after", 4'b1111, 1'b0, 1'b0, 1'b0);

    // 6b: bit order, 1,0,0,0 into both instances
    start = 1'b1; tick(); start = 1'b0;
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0); bit_in(1'b0);
    chk_m("t6_msb", 4'b1000, 1'b1, 1'b0, 1'b0);
    chk("t6_lsb_d_out", {4'h0, d_out_l}, 8'h01);
    chk("t6_lsb_ce_out", {7'h0, ce_l}, 8'h01);
    chk("t6_lsb_busy", {7'h0, busy_l}, 8'h00);
    chk("t6_lsb_abort", {7'h0, abort_l}, 8'h00);
    tick();
    chk("t6_lsb_ce_after", {7'h0, ce_l}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
